// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one booth_mult between NREQ requesters, one multiply in flight.
// Latency: accept T, mult_en T+1, product T+2 (1-cycle booth), resp_valid T+3; watchdog ends WAIT after MAX_WAIT cycles.
// Backpressure: req_ready only in IDLE; response held until resp_ready of the granted requester.
module booth_mult_arbiter #(
    parameter int NREQ     = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*15-1:0]   req_multiplicand,
    input  logic [NREQ*5-1:0]    req_multiplier,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [18:0]          resp_data,
    output logic                 resp_err,
    output logic                 busy,
    output logic                 mult_en,
    output logic [14:0]          multiplicand,
    output logic [4:0]           multiplier,
    input  logic                 mult_out_valid,
    input  logic [18:0]          mult_out
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_q;
    logic [PW-1:0] gnt_idx;
    logic          gnt_any;
    logic [CW-1:0] wd_cnt;

    // First valid requester after the last one served, wrapping around.
    always_comb begin
        int j;
        j       = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!gnt_any && req_valid[j[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = j[PW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_any) begin
            req_ready = NREQ'(1) << gnt_idx;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= PW'(NREQ - 1);
            gnt_q        <= '0;
            wd_cnt       <= '0;
            mult_en      <= 1'b0;
            multiplicand <= '0;
            multiplier   <= '0;
            resp_valid   <= '0;
            resp_data    <= '0;
            resp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        gnt_q        <= gnt_idx;
                        multiplicand <= req_multiplicand[15*int'(gnt_idx) +: 15];
                        multiplier   <= req_multiplier[5*int'(gnt_idx) +: 5];
                        mult_en      <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    mult_en <= 1'b0;
                    wd_cnt  <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // A product arriving on the last allowed cycle beats the timeout.
                    if (mult_out_valid) begin
                        resp_data  <= mult_out;
                        resp_err   <= 1'b0;
                        resp_valid <= NREQ'(1) << gnt_q;
                        state      <= RESP;
                    end else if (wd_cnt == CW'(MAX_WAIT - 1)) begin
                        resp_data  <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= NREQ'(1) << gnt_q;
                        state      <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready[gnt_q]) begin
                        resp_valid <= '0;
                        resp_data  <= '0;
                        resp_err   <= 1'b0;
                        ptr        <= gnt_q;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural booth_mult stub of programmable delay.
module tb_booth_mult_arbiter;
    localparam int NREQ     = 2;
    localparam int MAX_WAIT = 8;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*15-1:0] req_multiplicand = '0;
    logic [NREQ*5-1:0] req_multiplier = '0;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready = '0;
    logic [18:0]       resp_data;
    logic              resp_err;
    logic              busy;
    logic              mult_en;
    logic [14:0]       multiplicand;
    logic [4:0]        multiplier;
    logic              mult_out_valid;
    logic [18:0]       mult_out;

    int checks = 0;
    int errors = 0;

    int          stub_delay = 1;
    bit          stub_never = 1'b0;
    logic        stub_pend;
    int          stub_cnt;
    logic [18:0] stub_prod;

    always #5 clk = ~clk;

    booth_mult_arbiter #(.NREQ(NREQ), .MAX_WAIT(MAX_WAIT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_multiplicand (req_multiplicand),
        .req_multiplier   (req_multiplier),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .resp_err         (resp_err),
        .busy             (busy),
        .mult_en          (mult_en),
        .multiplicand     (multiplicand),
        .multiplier       (multiplier),
        .mult_out_valid   (mult_out_valid),
        .mult_out         (mult_out)
    );

    // booth_mult stand-in: product appears stub_delay cycles after mult_en
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_out_valid <= 1'b0;
            mult_out       <= '0;
            stub_pend      <= 1'b0;
            stub_cnt       <= 0;
            stub_prod      <= '0;
        end else begin
            mult_out_valid <= 1'b0;
            if (mult_en && !stub_never) begin
                if (stub_delay <= 1) begin
                    mult_out_valid <= 1'b1;
                    mult_out       <= $signed(multiplicand) * $signed(multiplier);
                end else begin
                    stub_pend <= 1'b1;
                    stub_cnt  <= stub_delay - 1;
                    stub_prod <= $signed(multiplicand) * $signed(multiplier);
                end
            end else if (stub_pend) begin
                if (stub_cnt == 1) begin
                    mult_out_valid <= 1'b1;
                    mult_out       <= stub_prod;
                    stub_pend      <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input int mc, input int mp);
        req_multiplicand[15*r +: 15] = 15'(mc);
        req_multiplier[5*r +: 5]     = 5'(mp);
    endtask

    // n = cycles waited for req_ready, -1 if it never came
    task automatic wait_ready(output int n);
        #1;
        n = 0;
        while (req_ready == '0 && n < 30) begin
            tick();
            n++;
        end
        if (req_ready == '0) n = -1;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (resp_valid == '0 && n < 30) begin
            tick();
            n++;
        end
        if (resp_valid == '0) n = -1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({req_ready, resp_valid, resp_err, busy, mult_en} !== '0)
            begin errors++; $display("FAIL reset_ctrl got %b want 0", {req_ready, resp_valid, resp_err, busy, mult_en}); end
        checks++;
        if ({resp_data, multiplicand, multiplier} !== '0)
            begin errors++; $display("FAIL reset_data got %h want 0", {resp_data, multiplicand, multiplier}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n;
        resp_ready = 2'b11;
        set_op(0, 9216, -16);
        req_valid = 2'b01;
        wait_ready(n);
        checks++;
        if (n !== 0 || req_ready !== 2'b01)
            begin errors++; $display("FAIL basic_accept got n=%0d ready=%b want 0/01", n, req_ready); end
        tick();
        req_valid = '0;
        checks++;
        if (mult_en !== 1'b1 || multiplicand !== 15'd9216 || multiplier !== 5'b10000)
            begin errors++; $display("FAIL basic_issue got en=%b a=%h b=%h want 1/2400/10", mult_en, multiplicand, multiplier); end
        tick();
        checks++;
        if (mult_en !== 1'b0 || busy !== 1'b1 || resp_valid !== 2'b00)
            begin errors++; $display("FAIL basic_wait got en=%b busy=%b rv=%b want 0/1/00", mult_en, busy, resp_valid); end
        wait_resp(n);
        checks++;
        if (n !== 1 || resp_valid !== 2'b01 || resp_data !== 19'(-147456) || resp_err !== 1'b0)
            begin errors++; $display("FAIL basic_resp got n=%0d rv=%b d=%h e=%b want 1/01/5c000/0", n, resp_valid, resp_data, resp_err); end
        tick();
        checks++;
        if (resp_valid !== 2'b00 || busy !== 1'b0)
            begin errors++; $display("FAIL basic_done got rv=%b busy=%b want 00/0", resp_valid, busy); end
    endtask

    task automatic test_fairness();
        int n;
        int m;
        int exp_g [4] = '{0, 1, 0, 1};
        logic [18:0] exp_d;
        do_reset();
        resp_ready = 2'b11;
        set_op(0, 100, 3);
        set_op(1, -3, 7);
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_d = (exp_g[t] == 0) ? 19'(300) : 19'(-21);
            wait_ready(n);
            checks++;
            if (req_ready !== (2'b01 << exp_g[t]))
                begin errors++; $display("FAIL fair_grant%0d got %b want %b", t, req_ready, 2'b01 << exp_g[t]); end
            tick();
            wait_resp(m);
            checks++;
            if (m !== 2 || resp_valid !== (2'b01 << exp_g[t]) || resp_data !== exp_d || resp_err !== 1'b0)
                begin errors++; $display("FAIL fair_resp%0d got m=%0d rv=%b d=%h want 2/%b/%h", t, m, resp_valid, resp_data, 2'b01 << exp_g[t], exp_d); end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_back_pressure();
        int n;
        resp_ready = 2'b00;
        set_op(0, -5, 5);
        req_valid = 2'b01;
        wait_ready(n);
        tick();
        req_valid = 2'b11;
        wait_resp(n);
        checks++;
        if (resp_valid !== 2'b01 || resp_data !== 19'(-25))
            begin errors++; $display("FAIL bp_resp got rv=%b d=%h want 01/%h", resp_valid, resp_data, 19'(-25)); end
        for (int c = 0; c < 5; c++) begin
            resp_ready = 2'b10;
            tick();
            checks++;
            if (resp_valid !== 2'b01 || resp_data !== 19'(-25) || resp_err !== 1'b0 || req_ready !== 2'b00)
                begin errors++; $display("FAIL bp_hold%0d got rv=%b d=%h e=%b rr=%b want 01/%h/0/00", c, resp_valid, resp_data, resp_err, req_ready, 19'(-25)); end
        end
        resp_ready = 2'b01;
        req_valid  = 2'b00;
        tick();
        checks++;
        if (resp_valid !== 2'b00 || busy !== 1'b0)
            begin errors++; $display("FAIL bp_release got rv=%b busy=%b want 00/0", resp_valid, busy); end
    endtask

    task automatic test_timeout();
        int n;
        int m;
        bit          tv_never [3] = '{1'b1, 1'b0, 1'b0};
        int          tv_delay [3] = '{0, 8, 9};
        logic        tv_err   [3] = '{1'b1, 1'b0, 1'b1};
        logic [18:0] tv_data  [3] = '{19'd0, 19'd25, 19'd0};
        resp_ready = 2'b11;
        set_op(1, 5, 5);
        for (int t = 0; t < 3; t++) begin
            stub_never = tv_never[t];
            stub_delay = tv_delay[t];
            req_valid  = 2'b10;
            wait_ready(n);
            checks++;
            if (req_ready !== 2'b10)
                begin errors++; $display("FAIL to_accept%0d got %b want 10", t, req_ready); end
            tick();
            req_valid = '0;
            wait_resp(m);
            checks++;
            if (m !== 9 || resp_valid !== 2'b10 || resp_err !== tv_err[t] || resp_data !== tv_data[t])
                begin errors++; $display("FAIL to_resp%0d got m=%0d rv=%b e=%b d=%h want 9/10/%b/%h", t, m, resp_valid, resp_err, resp_data, tv_err[t], tv_data[t]); end
            tick();
        end
        stub_never = 1'b0;
        stub_delay = 1;
    endtask

    task automatic test_reset_mid();
        int n;
        int m;
        bit seen;
        resp_ready = 2'b11;
        stub_delay = 5;
        set_op(0, 1000, 2);
        req_valid = 2'b01;
        wait_ready(n);
        tick();
        req_valid = '0;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, busy, mult_en} !== '0 || {resp_data, multiplicand, multiplier} !== '0)
            begin errors++; $display("FAIL rstmid_outputs got %b %h want 0", {req_ready, resp_valid, resp_err, busy, mult_en}, {resp_data, multiplicand, multiplier}); end
        stub_delay = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (resp_valid !== 2'b00 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen)
            begin errors++; $display("FAIL rstmid_quiet got activity=1 want 0"); end
        set_op(1, -3, 7);
        req_valid = 2'b11;
        wait_ready(n);
        checks++;
        if (req_ready !== 2'b01)
            begin errors++; $display("FAIL rstmid_tie got %b want 01", req_ready); end
        tick();
        req_valid = 2'b10;
        wait_resp(m);
        checks++;
        if (resp_valid !== 2'b01 || resp_data !== 19'd2000 || resp_err !== 1'b0)
            begin errors++; $display("FAIL rstmid_r0 got rv=%b d=%h e=%b want 01/007d0/0", resp_valid, resp_data, resp_err); end
        tick();
        wait_ready(n);
        checks++;
        if (req_ready !== 2'b10)
            begin errors++; $display("FAIL rstmid_r1_accept got %b want 10", req_ready); end
        tick();
        req_valid = '0;
        wait_resp(m);
        checks++;
        if (m !== 2 || resp_valid !== 2'b10 || resp_data !== 19'(-21) || resp_err !== 1'b0)
            begin errors++; $display("FAIL rstmid_r1 got m=%0d rv=%b d=%h e=%b want 2/10/%h/0", m, resp_valid, resp_data, resp_err, 19'(-21)); end
        tick();
    endtask

    task automatic test_sweep();
        int n;
        int m;
        int ex;
        logic [18:0] e19;
        int corners [5] = '{-16384, -1, 0, 1, 16383};
        resp_ready = 2'b11;
        stub_delay = 1;
        for (int mp = -16; mp <= 15; mp++) begin
            for (int c = 0; c < 5; c++) begin
                ex  = corners[c] * mp;
                e19 = ex[18:0];
                set_op(1, corners[c], mp);
                req_valid = 2'b10;
                wait_ready(n);
                tick();
                req_valid = '0;
                wait_resp(m);
                checks++;
                if (n < 0 || m !== 2 || resp_valid !== 2'b10 || resp_data !== e19 || resp_err !== 1'b0)
                    begin errors++; $display("FAIL sweep %0d*%0d got n=%0d m=%0d rv=%b d=%h want 2/10/%h", corners[c], mp, n, m, resp_valid, resp_data, e19); end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fairness();
        test_back_pressure();
        test_timeout();
        test_reset_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "bench timeout");
    end
endmodule
